// File: rtl/seq_always_stage14_pkg.sv
// Shared types for the stage-14 accumulate-and-buffer block: fold opcodes and FIFO occupancy states.
package seq_always_stage14_pkg;

    typedef enum logic [1:0] {
        PASS = 2'b00,
        OR   = 2'b01,
        XOR  = 2'b10,
        ADD  = 2'b11
    } fold_mode_e;

    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        PARTIAL = 2'b01,
        FULL    = 2'b10
    } fifo_state_e;

endpackage

// File: rtl/seq_always_stage14_fold_alu.sv
// Combinational fold of the incoming value into the accumulator base; zero latency, no handshake.
module seq_always_stage14_fold_alu
    import seq_always_stage14_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  fold_mode_e       mode,
    input  logic [WIDTH-1:0] acc_base,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] fold
);

    always_comb begin
        fold = in_data;
        case (mode)
            PASS:    fold = in_data;
            OR:      fold = acc_base | in_data;
            XOR:     fold = acc_base ^ in_data;
            // Carry out of the top bit is dropped: result is modulo 2^WIDTH.
            ADD:     fold = acc_base + in_data;
            default: fold = in_data;
        endcase
    end

endmodule

// File: rtl/seq_always_stage14_accum_fifo.sv
// Folds each accepted value into a running accumulator and queues the result in a DEPTH-entry FIFO.
// One-cycle push-to-head latency (no bypass); in_ready drops only when full and ignores out_ready.
module seq_always_stage14_accum_fifo
    import seq_always_stage14_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count,
    output logic             drop_seen
);

    localparam int PW = $clog2(DEPTH);

    fifo_state_e      state_q, state_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             drop_q, drop_d;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             push, pop;
    logic [WIDTH-1:0] acc_base, fold;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = mem[rd_ptr_q];
    assign count     = count_q;
    assign drop_seen = drop_q;

    assign push     = in_valid & in_ready;
    assign pop      = out_valid & out_ready;
    assign acc_base = clear ? '0 : acc_q;

    seq_always_stage14_fold_alu #(
        .WIDTH (WIDTH)
    ) u_fold_alu (
        .mode     (fold_mode_e'(mode)),
        .acc_base (acc_base),
        .in_data  (in_data),
        .fold     (fold)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (push) state_d = PARTIAL;
            end
            PARTIAL: begin
                if (pop && !push && count_q == CW'(1))
                    state_d = EMPTY;
                else if (push && !pop && count_q == CW'(DEPTH - 1))
                    state_d = FULL;
            end
            FULL: begin
                if (pop) state_d = PARTIAL;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;

        count_d = count_q;
        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (pop && !push)
            count_d = count_q - CW'(1);

        acc_d = acc_q;
        if (push)
            acc_d = fold;
        else if (clear)
            acc_d = '0;

        // clear takes priority over a same-cycle drop.
        drop_d = drop_q;
        if (clear)
            drop_d = 1'b0;
        else if (in_valid && !in_ready)
            drop_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= EMPTY;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            acc_q    <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= fold;
    end

endmodule

// File: tb/tb_seq_always_stage14_accum_fifo.sv
// Directed bench with a queue-based reference model checked every cycle on the falling edge.
module tb_seq_always_stage14_accum_fifo;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic [1:0]       mode;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;
    logic             drop_seen;

    always #5 clk = ~clk;

    seq_always_stage14_accum_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .drop_seen (drop_seen)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_acc  = '0;
    logic             m_drop = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] mfold(input logic [1:0] m, input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] d);
        int sum;
        case (m)
            2'd0:    return d;
            2'd1:    return b | d;
            2'd2:    return b ^ d;
            default: begin
                sum = int'(b) + int'(d);
                return WIDTH'(sum % (1 << WIDTH));
            end
        endcase
    endfunction

    // Advance one clock; the model sees the same inputs the DUT samples on this edge.
    task automatic step();
        logic             do_push, do_pop, was_full;
        logic [WIDTH-1:0] f;
        was_full = (mq.size() == DEPTH);
        do_push  = in_valid && !was_full;
        do_pop   = out_ready && (mq.size() != 0);
        f        = mfold(mode, clear ? '0 : m_acc, in_data);
        @(posedge clk);
        if (in_valid && was_full) m_drop = 1'b1;
        if (clear) m_drop = 1'b0;
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            mq.push_back(f);
            m_acc = f;
        end else if (clear) begin
            m_acc = '0;
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic [1:0] m,
                         input logic c, input logic r);
        in_valid  = v;
        in_data   = d;
        mode      = m;
        clear     = c;
        out_ready = r;
    endtask

    task automatic push_one(input logic [WIDTH-1:0] d, input logic [1:0] m, input logic c);
        drive(1'b1, d, m, c, 1'b0);
        step();
        drive(1'b0, '0, m, 1'b0, 1'b0);
    endtask

    task automatic pop_expect(input string nm, input logic [WIDTH-1:0] exp);
        chk({nm, "_valid"}, out_valid, 1'b1);
        chk(nm, out_data, exp);
        drive(1'b0, '0, mode, 1'b0, 1'b1);
        step();
        out_ready = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 2 * DEPTH && mq.size() != 0; i++) step();
        out_ready = 1'b0;
        chk("drain_empty", out_valid, 1'b0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_out_valid", out_valid, mq.size() != 0);
            chk("m_in_ready", in_ready, mq.size() != DEPTH);
            chk("m_count", count, mq.size());
            chk("m_drop_seen", drop_seen, m_drop);
            if (mq.size() != 0) chk("m_out_data", out_data, mq[0]);
        end
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, 2'b00, 1'b0, 1'b0);
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_count", count, 0);
        chk("rst_drop", drop_seen, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Build count=2, acc=6, then reset asynchronously mid-cycle.
        push_one(4'h2, 2'b11, 1'b0);
        push_one(4'h4, 2'b11, 1'b0);
        chk("pre_rst_count", count, 2);
        #2;
        rst = 1'b1;
        mq.delete();
        m_acc  = '0;
        m_drop = 1'b0;
        #1;
        chk("async_out_valid", out_valid, 1'b0);
        chk("async_in_ready", in_ready, 1'b1);
        chk("async_count", count, 0);
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        push_one(4'h1, 2'b11, 1'b0);
        pop_expect("post_rst_acc_zero", 4'h1);

        // Pass-through ordering with downstream stalled.
        push_one(4'h3, 2'b00, 1'b0);
        push_one(4'h5, 2'b00, 1'b0);
        push_one(4'h9, 2'b00, 1'b0);
        chk("pass_count", count, 3);
        chk("pass_partial", {out_valid, in_ready}, 2'b11);
        pop_expect("pass_0", 4'h3);
        pop_expect("pass_1", 4'h5);
        pop_expect("pass_2", 4'h9);
        chk("pass_empty", out_valid, 1'b0);

        // Add with carry discarded, then xor.
        push_one(4'h9, 2'b11, 1'b1);
        push_one(4'h9, 2'b11, 1'b0);
        push_one(4'hF, 2'b10, 1'b0);
        pop_expect("add_0", 4'h9);
        pop_expect("add_wrap", 4'h2);
        pop_expect("xor", 4'hD);

        // Fill, offer while full, pop with in_valid held, refill at wrapped slot.
        push_one(4'h1, 2'b00, 1'b0);
        push_one(4'h2, 2'b00, 1'b0);
        push_one(4'h3, 2'b00, 1'b0);
        push_one(4'h4, 2'b00, 1'b0);
        chk("full_in_ready", in_ready, 1'b0);
        chk("full_count", count, 4);
        drive(1'b1, 4'h7, 2'b00, 1'b0, 1'b0);
        step();
        chk("drop_set", drop_seen, 1'b1);
        chk("drop_no_write", count, 4);
        drive(1'b1, 4'h7, 2'b00, 1'b0, 1'b1);
        step();
        chk("pop_full_count", count, 3);
        chk("pop_full_ready", in_ready, 1'b1);
        drive(1'b1, 4'h8, 2'b00, 1'b0, 1'b0);
        step();
        chk("refill_count", count, 4);
        drive(1'b0, '0, 2'b00, 1'b0, 1'b0);
        pop_expect("wrap_0", 4'h2);
        pop_expect("wrap_1", 4'h3);
        pop_expect("wrap_2", 4'h4);
        pop_expect("wrap_3", 4'h8);

        // Clear coincident with push: OR starts from zero, sticky flag drops.
        push_one(4'hF, 2'b00, 1'b0);
        push_one(4'h4, 2'b01, 1'b1);
        chk("clear_drop", drop_seen, 1'b0);
        pop_expect("clr_0", 4'hF);
        pop_expect("clr_push", 4'h4);
        push_one(4'h1, 2'b01, 1'b0);
        pop_expect("clr_acc", 4'h5);

        // Steady push+pop at occupancy 2.
        push_one(4'hA, 2'b00, 1'b0);
        push_one(4'hB, 2'b00, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, WIDTH'(i), 2'b00, 1'b0, 1'b1);
            step();
            chk("steady_count", count, 2);
        end
        drive(1'b0, '0, 2'b00, 1'b0, 1'b0);
        pop_expect("steady_0", 4'h6);
        pop_expect("steady_1", 4'h7);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_always_stage14_accum_fifo.md
Name: seq_always_stage14_accum_fifo

Overview:
Sequential-always elaboration fixture for stage 14. It sits directly downstream of the stage-13 combinational case/if blocks. It consumes a WIDTH-bit value over a valid/ready handshake, folds the value into a running accumulator using a case-selected operation, and buffers each result in a DEPTH-entry FIFO. It exercises always_ff with async reset, if/else and case in clocked logic, an explicit FSM, pointer wrap-around and a sticky flag.

Parameters:
WIDTH, 4, data/accumulator width in bits (>=1)
DEPTH, 4, FIFO entries; power of two, >=2
CW, $clog2(DEPTH+1), occupancy counter width (derived localparam, not overridable)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
clear  input  1  synchronous accumulator/flag clear
mode  input  2  fold op: 00 pass, 01 OR, 10 XOR, 11 add
in_valid  input  1  upstream data valid
in_ready  output  1  block can accept
in_data  input  WIDTH  upstream value
out_valid  output  1  FIFO head valid
out_ready  input  1  downstream accepts head
out_data  output  WIDTH  FIFO head value
count  output  CW  current occupancy
drop_seen  output  1  sticky: a valid was offered while full

Behaviour:
- Reset: rst=1 forces state=EMPTY, rd_ptr=wr_ptr=0, count=0, acc=0, drop_seen=0 immediately, without waiting for a clock. Consequently out_valid=0, in_ready=1, count=0. FIFO memory is not reset, and out_data is don't-care while out_valid=0.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready = (state != FULL). It is a function of registered state only and never depends on out_ready; there is no push-when-full-with-pop.
- out_valid = (state != EMPTY). out_data = mem[rd_ptr].
- Fold, computed combinationally from acc_base and in_data:
  - acc_base = clear ? 0 : acc.
  - mode 00: in_data.
  - mode 01: acc_base | in_data.
  - mode 10: acc_base ^ in_data.
  - mode 11: (acc_base + in_data) mod 2^WIDTH; the carry is discarded.
- On push: mem[wr_ptr] <= fold, acc <= fold, wr_ptr <= wr_ptr+1 (wraps modulo DEPTH).
- On clear without push: acc <= 0.
- On pop: rd_ptr <= rd_ptr+1 (wraps modulo DEPTH).
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency: a value pushed at edge N is visible on out_valid/out_data after edge N. There is no empty-bypass.
- FSM states (in package):
  - EMPTY -> PARTIAL on push. Pop is impossible in EMPTY.
  - PARTIAL -> EMPTY on pop-only when count==1.
  - PARTIAL -> FULL on push-only when count==DEPTH-1.
  - PARTIAL stays PARTIAL otherwise, including simultaneous push+pop.
  - FULL -> PARTIAL on pop. Push is impossible in FULL.
  - Invariant: state agrees with count (0 -> EMPTY, DEPTH -> FULL).
- drop_seen: set on any cycle with in_valid & !in_ready. Cleared by clear; if set and clear occur in the same cycle, clear wins. Held otherwise.
- Reset mid-operation discards all queued entries and the accumulator; the first post-reset push starts from acc=0.
- mode and clear are sampled only on the push/clear edge. A mode change has no effect on stored entries.

Decomposition:
- Package seq_always_stage14_pkg:
  - fold_mode_e enum (PASS=2'b00, OR=2'b01, XOR=2'b10, ADD=2'b11).
  - fifo_state_e enum (EMPTY, PARTIAL, FULL).
- One sub-module: seq_always_stage14_fold_alu. Purely combinational always_comb case on mode, parameterised by WIDTH, with a default arm that assigns (no latch).
- The parent holds the FSM, pointers, counter, memory and sticky flag in always_ff blocks.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with count=2, acc=4'h6 -> same cycle out_valid=0, in_ready=1, count=0. After release, push 4'h1 with mode=11 -> entry 4'h1.
- Pass and order: mode=00, out_ready=0, push 3,5,9 -> count=3, state PARTIAL, out_data=3. Then out_ready=1 -> out_data sequence 3,5,9, then out_valid=0, state EMPTY.
- Add wrap: mode=11 from acc=0, push 9 then 9 -> entries 9, 2; acc=2. Then mode=10, push 4'hF -> entry 4'hD.
- Full and drop: push 4 entries -> in_ready=0, state FULL, count=4. Hold in_valid=1 one more cycle -> no write, drop_seen=1. Pop with in_valid=1 -> count=3 and no push that cycle. Next cycle in_ready=1 and the push lands at wrapped wr_ptr=0.
- Clear with push: acc=4'hF, mode=01, clear=1, push 4'h4 -> stored entry 4'h4, acc=4'h4, drop_seen=0.
- Steady push+pop at count=2 over 8 cycles -> count stays 2, state PARTIAL, pointers wrap twice, outputs in FIFO order.
